rv_lsu: RTL and testbench
=========================

// Module: rv_lsu
// PURPOSE
//  Load-store unit for the RV32IM core. Takes load/store requests from the execute
//  stage with a size code (MEM_ACCESS_* from rv_lsu_pkg) and issues word-aligned
//  req/gnt/rvalid transactions to the data memory port. Generates byte enables,
//  replicates store data, sign/zero-extends load data, flags misaligned/illegal
//  accesses and stalls the pipeline until each transaction completes.
// PARAMETERS
//  TIMEOUT_CYCLES  0  Max cycles in REQ+WAIT before bus fault; 0 disables timeout.
// PORTS
//  clk_i             in   1   core clock
//  arstn_i           in   1   asynchronous active-low reset
//  lsu_req_i         in   1   access request; held by core while lsu_stall_o=1
//  lsu_we_i          in   1   1=store, 0=load
//  lsu_size_i        in   3   MEM_ACCESS_* code
//  lsu_addr_i        in   32  byte address
//  lsu_data_i        in   32  store data (LSBs significant)
//  lsu_data_o        out  32  extended load data, valid when lsu_valid_o=1
//  lsu_valid_o       out  1   load result valid (1-cycle pulse)
//  lsu_stall_o       out  1   hold pipeline
//  lsu_misaligned_o  out  1   misaligned access rejected (1-cycle, comb)
//  lsu_illegal_o     out  1   unsupported size rejected (1-cycle, comb)
//  lsu_fault_o       out  1   bus timeout (1-cycle pulse)
//  data_req_o        out  1   memory request
//  data_we_o         out  1   memory write
//  data_be_o         out  4   byte enables
//  data_addr_o       out  32  {addr[31:2],2'b00}
//  data_wdata_o      out  32  replicated store data
//  data_gnt_i        in   1   request granted
//  data_rvalid_i     in   1   response valid (loads and stores)
//  data_rdata_i      in   32  read data
// BEHAVIOUR
//  - Reset (async, arstn_i=0): state IDLE, timeout counter 0, all data_* outputs 0;
//    lsu_valid_o/lsu_fault_o 0; stall/misaligned/illegal 0 (no req in IDLE).
//  - Legality: WORD needs addr[1:0]=0, HALF/UHALF need addr[0]=0. DWORD/UWORD and
//    codes 7 illegal always; UHALF/UBYTE illegal for stores. Illegal beats misaligned.
//  - FSM IDLE->REQ->WAIT->IDLE.
//    IDLE: req & legal -> register we, be, aligned addr, wdata, size, addr[1:0];
//      go REQ; stall=1. req & error -> misaligned/illegal=1, stall=0, no bus access.
//    REQ: data_req_o=1, all data_* stable until data_gnt_i; on gnt -> WAIT. stall=1.
//    WAIT: data_req_o=0; on data_rvalid_i -> IDLE, stall=0 that cycle; for loads
//      lsu_valid_o=1 and lsu_data_o driven combinationally from data_rdata_i.
//      The still-asserted lsu_req_i in that cycle is NOT re-accepted.
//  - Min latency: accept T, req T+1, gnt T+1, rvalid T+2 -> stall low at T+2.
//  - data_rvalid_i in IDLE/REQ ignored; data_gnt_i outside REQ ignored.
//  - be: WORD 1111; HALF 0011<<addr[1:0]; BYTE 0001<<addr[1:0].
//    wdata: WORD d; HALF {2{d[15:0]}}; BYTE {4{d[7:0]}}.
//  - Load: s = rdata >> (8*off); BYTE sext s[7:0], UBYTE zext s[7:0], HALF sext
//    s[15:0], UHALF zext s[15:0], WORD rdata. lsu_data_o=0 when lsu_valid_o=0.
//  - Timeout (TIMEOUT_CYCLES>0): counter counts cycles in REQ/WAIT, cleared in IDLE;
//    reaching TIMEOUT_CYCLES -> lsu_fault_o pulse, stall=0, data_req_o drop, IDLE.
//    Later stray rvalid ignored.
//  - Reset mid-transaction aborts immediately; no output pulse generated.
// TESTING
//  1 SW 0xDEADBEEF @0x100, gnt same cycle, rvalid next -> be=1111, addr=0x100,
//    wdata=0xDEADBEEF, stall high 2 cycles, lsu_valid_o stays 0.
//  2 LB @0x103, rdata=0x80FFFFFF -> be=1000, lsu_data_o=0xFFFFFF80; LBU ->0x00000080;
//    LH @0x102 rdata=0x8001_1234 -> 0xFFFF8001; LHU -> 0x00008001.
//  3 SH 0xABCD @0x101 -> misaligned=1 one cycle, stall=0, data_req_o never set;
//    SW @0x102 same; store with UHALF size -> illegal=1, no bus request.
//  4 gnt delayed 3 cycles, rvalid 2 later -> data_req_o/addr/be/wdata stable 3
//    cycles, stall held until rvalid, exactly one transaction per request.
//  5 TIMEOUT_CYCLES=8, no gnt -> lsu_fault_o at 8th REQ cycle, back to IDLE; late
//    rvalid ignored; back-to-back SB then LW both complete correctly.
//  6 arstn_i low during WAIT -> data_req_o=0, stall=0 at once; post-reset LW works.

Source files
------------

// File: rtl/rv_lsu.sv
// Load-store unit: turns execute-stage load/store requests into word-aligned
// req/gnt/rvalid memory transactions and sign/zero-extends returned load data.

package rv_lsu_pkg;
   localparam logic [2:0] MEM_ACCESS_WORD  = 3'd0;
   localparam logic [2:0] MEM_ACCESS_HALF  = 3'd1;
   localparam logic [2:0] MEM_ACCESS_BYTE  = 3'd2;
   localparam logic [2:0] MEM_ACCESS_UHALF = 3'd3;
   localparam logic [2:0] MEM_ACCESS_UBYTE = 3'd4;
   localparam logic [2:0] MEM_ACCESS_DWORD = 3'd5;
   localparam logic [2:0] MEM_ACCESS_UWORD = 3'd6;
endpackage

module rv_lsu
   import rv_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic        clk_i,
   input  logic        arstn_i,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [2:0]  lsu_size_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_data_i,
   output logic [31:0] lsu_data_o,
   output logic        lsu_valid_o,
   output logic        lsu_stall_o,
   output logic        lsu_misaligned_o,
   output logic        lsu_illegal_o,
   output logic        lsu_fault_o,
   output logic        data_req_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

   function automatic logic [3:0] calc_be(input logic [2:0] size, input logic [1:0] off);
      case (size)
         MEM_ACCESS_HALF, MEM_ACCESS_UHALF: calc_be = 4'b0011 << off;
         MEM_ACCESS_BYTE, MEM_ACCESS_UBYTE: calc_be = 4'b0001 << off;
         default:                           calc_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] calc_wdata(input logic [2:0] size, input logic [31:0] d);
      case (size)
         MEM_ACCESS_HALF, MEM_ACCESS_UHALF: calc_wdata = {2{d[15:0]}};
         MEM_ACCESS_BYTE, MEM_ACCESS_UBYTE: calc_wdata = {4{d[7:0]}};
         default:                           calc_wdata = d;
      endcase
   endfunction

   function automatic logic [31:0] load_ext(input logic [2:0] size, input logic [1:0] off,
                                            input logic [31:0] rdata);
      logic [31:0] s;
      s = rdata >> {off, 3'b000};
      case (size)
         MEM_ACCESS_BYTE:  load_ext = {{24{s[7]}}, s[7:0]};
         MEM_ACCESS_UBYTE: load_ext = {24'h000000, s[7:0]};
         MEM_ACCESS_HALF:  load_ext = {{16{s[15]}}, s[15:0]};
         MEM_ACCESS_UHALF: load_ext = {16'h0000, s[15:0]};
         default:          load_ext = rdata;
      endcase
   endfunction

   state_t      state_r;
   logic [31:0] cnt_r;
   logic [2:0]  size_r;
   logic [1:0]  off_r;
   logic        data_req_r;
   logic        data_we_r;
   logic [3:0]  data_be_r;
   logic [31:0] data_addr_r;
   logic [31:0] data_wdata_r;

   logic        illegal_s;
   logic        misalign_s;
   logic        idle_req_s;
   logic        accept_s;
   logic        granted_s;
   logic        done_s;
   logic        fault_s;
   logic [31:0] cnt_inc_s;

   // Size/alignment legality of the incoming request; illegal takes precedence.
   always_comb begin
      illegal_s  = 1'b0;
      misalign_s = 1'b0;
      case (lsu_size_i)
         MEM_ACCESS_WORD:  misalign_s = (lsu_addr_i[1:0] != 2'b00);
         MEM_ACCESS_HALF:  misalign_s = lsu_addr_i[0];
         MEM_ACCESS_UHALF: begin
            illegal_s  = lsu_we_i;
            misalign_s = lsu_addr_i[0];
         end
         MEM_ACCESS_BYTE:  illegal_s = 1'b0;
         MEM_ACCESS_UBYTE: illegal_s = lsu_we_i;
         default:          illegal_s = 1'b1;
      endcase
   end

   assign idle_req_s = (state_r == ST_IDLE) && lsu_req_i;
   assign accept_s   = idle_req_s && !illegal_s && !misalign_s;
   assign granted_s  = (state_r == ST_REQ) && data_gnt_i;
   assign done_s     = (state_r == ST_WAIT) && data_rvalid_i;
   // A grant or response arriving in the last allowed cycle wins over the timeout.
   assign fault_s    = TO_EN && ((state_r == ST_REQ) || (state_r == ST_WAIT)) &&
                       (cnt_r >= TO_LAST) && !granted_s && !done_s;
   assign cnt_inc_s  = TO_EN ? (cnt_r + 32'd1) : 32'd0;

   assign lsu_illegal_o    = idle_req_s && illegal_s;
   assign lsu_misaligned_o = idle_req_s && !illegal_s && misalign_s;
   assign lsu_fault_o      = fault_s;
   assign lsu_valid_o      = done_s && !data_we_r;
   assign lsu_data_o       = lsu_valid_o ? load_ext(size_r, off_r, data_rdata_i) : 32'h0000_0000;
   assign lsu_stall_o      = accept_s ||
                             ((state_r == ST_REQ) && !fault_s) ||
                             ((state_r == ST_WAIT) && !done_s && !fault_s);

   assign data_req_o   = data_req_r;
   assign data_we_o    = data_we_r;
   assign data_be_o    = data_be_r;
   assign data_addr_o  = data_addr_r;
   assign data_wdata_o = data_wdata_r;

   // Transaction FSM with registered memory-port outputs and timeout counter.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_r      <= ST_IDLE;
         cnt_r        <= 32'd0;
         size_r       <= 3'd0;
         off_r        <= 2'd0;
         data_req_r   <= 1'b0;
         data_we_r    <= 1'b0;
         data_be_r    <= 4'd0;
         data_addr_r  <= 32'd0;
         data_wdata_r <= 32'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               cnt_r <= 32'd0;
               if (accept_s) begin
                  state_r      <= ST_REQ;
                  data_req_r   <= 1'b1;
                  data_we_r    <= lsu_we_i;
                  data_be_r    <= calc_be(lsu_size_i, lsu_addr_i[1:0]);
                  data_addr_r  <= {lsu_addr_i[31:2], 2'b00};
                  data_wdata_r <= calc_wdata(lsu_size_i, lsu_data_i);
                  size_r       <= lsu_size_i;
                  off_r        <= lsu_addr_i[1:0];
               end
            end
            ST_REQ: begin
               if (granted_s) begin
                  state_r    <= ST_WAIT;
                  data_req_r <= 1'b0;
                  cnt_r      <= cnt_inc_s;
               end else if (fault_s) begin
                  state_r    <= ST_IDLE;
                  data_req_r <= 1'b0;
                  cnt_r      <= 32'd0;
               end else begin
                  cnt_r <= cnt_inc_s;
               end
            end
            ST_WAIT: begin
               if (done_s || fault_s) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= 32'd0;
               end else begin
                  cnt_r <= cnt_inc_s;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               data_req_r <= 1'b0;
               cnt_r      <= 32'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv_lsu.sv
// Directed bench for rv_lsu: stores, extended loads, rejected accesses,
// delayed grant, bus timeout, back-to-back traffic and mid-transaction reset.

module tb_rv_lsu;
   import rv_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        arstn = 1'b0;
   logic        lsu_req = 1'b0;
   logic        lsu_we = 1'b0;
   logic [2:0]  lsu_size = 3'd0;
   logic [31:0] lsu_addr = 32'd0;
   logic [31:0] lsu_wd = 32'd0;
   logic [31:0] lsu_rd;
   logic        lsu_valid, lsu_stall, lsu_mis, lsu_ill, lsu_fault;
   logic        data_req, data_we;
   logic [3:0]  data_be;
   logic [31:0] data_addr, data_wdata;
   logic        data_gnt = 1'b0;
   logic        data_rvalid = 1'b0;
   logic [31:0] data_rdata = 32'd0;

   int total = 0;
   int bad = 0;

   // observations collected by run_txn
   int          obs_stall, obs_req, obs_valid_n, obs_fault_n, obs_fault_k;
   logic        obs_done, obs_stable, obs_mis, obs_ill, obs_we;
   logic [3:0]  obs_be;
   logic [31:0] obs_addr, obs_wdata, obs_ldata;

   always #5 clk = ~clk;

   rv_lsu #(.TIMEOUT_CYCLES(8)) dut (
      .clk_i(clk), .arstn_i(arstn),
      .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_size_i(lsu_size),
      .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_wd), .lsu_data_o(lsu_rd),
      .lsu_valid_o(lsu_valid), .lsu_stall_o(lsu_stall),
      .lsu_misaligned_o(lsu_mis), .lsu_illegal_o(lsu_ill), .lsu_fault_o(lsu_fault),
      .data_req_o(data_req), .data_we_o(data_we), .data_be_o(data_be),
      .data_addr_o(data_addr), .data_wdata_o(data_wdata),
      .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata)
   );

   // Drives one request starting at posedge+1 in IDLE. gnt_wait = REQ cycles before
   // the grant cycle, rv_wait = WAIT cycles before the response cycle.
   task automatic run_txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input int gnt_wait, input int rv_wait,
                          input logic [31:0] rdata);
      obs_stall = 0; obs_req = 0; obs_valid_n = 0; obs_fault_n = 0; obs_fault_k = -1;
      obs_done = 1'b0; obs_stable = 1'b1; obs_mis = 1'b0; obs_ill = 1'b0; obs_we = 1'b0;
      obs_be = 4'd0; obs_addr = 32'd0; obs_wdata = 32'd0; obs_ldata = 32'd0;
      lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_addr = addr; lsu_wd = wd;
      for (int k = 0; k < 40; k++) begin
         data_gnt    = (k == 1 + gnt_wait);
         data_rvalid = (k == 2 + gnt_wait + rv_wait);
         data_rdata  = data_rvalid ? rdata : 32'h0;
         @(negedge clk);
         if (k == 0) begin
            obs_mis = lsu_mis;
            obs_ill = lsu_ill;
         end
         if (lsu_stall) obs_stall++;
         if (lsu_fault) begin
            obs_fault_n++;
            obs_fault_k = k;
         end
         if (lsu_valid) begin
            obs_valid_n++;
            obs_ldata = lsu_rd;
         end
         if (data_req) begin
            if (obs_req == 0) begin
               obs_be = data_be; obs_addr = data_addr; obs_wdata = data_wdata; obs_we = data_we;
            end else if (data_be !== obs_be || data_addr !== obs_addr ||
                         data_wdata !== obs_wdata || data_we !== obs_we) begin
               obs_stable = 1'b0;
            end
            obs_req++;
         end
         if (!lsu_stall) begin
            obs_done = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      lsu_req = 1'b0; data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = 32'h0;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (data_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", data_req); end
      total++; if ({data_we, data_be, data_addr, data_wdata} !== 69'd0) begin bad++;
         $display("FAIL rst_data got=%b/%h/%h/%h exp=0", data_we, data_be, data_addr, data_wdata); end
      total++; if ({lsu_stall, lsu_valid, lsu_fault, lsu_mis, lsu_ill} !== 5'd0) begin bad++;
         $display("FAIL rst_flags got=%b exp=00000", {lsu_stall, lsu_valid, lsu_fault, lsu_mis, lsu_ill}); end
      total++; if (lsu_rd !== 32'h0) begin bad++; $display("FAIL rst_ldata got=%h exp=0", lsu_rd); end
      arstn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_store_word;
      run_txn(1'b1, MEM_ACCESS_WORD, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
      total++; if (obs_be !== 4'b1111) begin bad++; $display("FAIL sw_be got=%b exp=1111", obs_be); end
      total++; if (obs_addr !== 32'h100) begin bad++; $display("FAIL sw_addr got=%h exp=00000100", obs_addr); end
      total++; if (obs_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wdata got=%h exp=deadbeef", obs_wdata); end
      total++; if (obs_we !== 1'b1) begin bad++; $display("FAIL sw_we got=%b exp=1", obs_we); end
      total++; if (obs_stall != 2) begin bad++; $display("FAIL sw_stall_cycles got=%0d exp=2", obs_stall); end
      total++; if (obs_valid_n != 0) begin bad++; $display("FAIL sw_valid got=%0d exp=0", obs_valid_n); end
      run_txn(1'b1, MEM_ACCESS_HALF, 32'h402, 32'hCAFEBEEF, 0, 0, 32'h0);
      total++; if ({obs_be, obs_addr, obs_wdata} !== {4'b1100, 32'h400, 32'hBEEFBEEF}) begin bad++;
         $display("FAIL sh_fields got=%b/%h/%h exp=1100/00000400/beefbeef", obs_be, obs_addr, obs_wdata); end
   endtask

   task automatic test_loads;
      logic [2:0]  sz [5] = '{MEM_ACCESS_BYTE, MEM_ACCESS_UBYTE, MEM_ACCESS_HALF, MEM_ACCESS_UHALF, MEM_ACCESS_WORD};
      logic [31:0] ad [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h104};
      logic [31:0] rd [5] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80011234, 32'h80011234, 32'h89ABCDEF};
      logic [31:0] ex [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'h89ABCDEF};
      logic [3:0]  eb [5] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1111};
      logic [31:0] ea [5] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h104};
      for (int i = 0; i < 5; i++) begin
         run_txn(1'b0, sz[i], ad[i], 32'h0, 0, 0, rd[i]);
         total++; if (obs_ldata !== ex[i]) begin bad++; $display("FAIL load%0d_data got=%h exp=%h", i, obs_ldata, ex[i]); end
         total++; if (obs_be !== eb[i] || obs_addr !== ea[i]) begin bad++;
            $display("FAIL load%0d_be_addr got=%b/%h exp=%b/%h", i, obs_be, obs_addr, eb[i], ea[i]); end
         total++; if (obs_valid_n != 1 || obs_we !== 1'b0) begin bad++;
            $display("FAIL load%0d_valid got=%0d/%b exp=1/0", i, obs_valid_n, obs_we); end
      end
   endtask

   task automatic test_errors;
      logic        we [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [2:0]  sz [4] = '{MEM_ACCESS_HALF, MEM_ACCESS_WORD, MEM_ACCESS_UHALF, MEM_ACCESS_DWORD};
      logic [31:0] ad [4] = '{32'h101, 32'h102, 32'h100, 32'h101};
      logic        em [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic        ei [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         run_txn(we[i], sz[i], ad[i], 32'h0000ABCD, 0, 0, 32'h0);
         total++; if (obs_mis !== em[i] || obs_ill !== ei[i]) begin bad++;
            $display("FAIL err%0d_flags got=mis%b/ill%b exp=mis%b/ill%b", i, obs_mis, obs_ill, em[i], ei[i]); end
         @(negedge clk);
         total++; if (obs_stall != 0 || obs_req != 0 || data_req !== 1'b0) begin bad++;
            $display("FAIL err%0d_nobus got=stall%0d/req%0d/%b exp=0/0/0", i, obs_stall, obs_req, data_req); end
         total++; if (lsu_mis !== 1'b0 || lsu_ill !== 1'b0) begin bad++;
            $display("FAIL err%0d_pulse got=%b%b exp=00", i, lsu_mis, lsu_ill); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stall_gnt;
      run_txn(1'b1, MEM_ACCESS_BYTE, 32'h201, 32'h000000A5, 3, 1, 32'h0);
      total++; if (obs_req != 4 || obs_stable !== 1'b1) begin bad++;
         $display("FAIL slow_req got=%0d/stable%b exp=4/1", obs_req, obs_stable); end
      total++; if ({obs_be, obs_addr, obs_wdata} !== {4'b0010, 32'h200, 32'hA5A5A5A5}) begin bad++;
         $display("FAIL slow_fields got=%b/%h/%h exp=0010/00000200/a5a5a5a5", obs_be, obs_addr, obs_wdata); end
      total++; if (obs_stall != 6 || obs_done !== 1'b1) begin bad++;
         $display("FAIL slow_stall got=%0d/done%b exp=6/1", obs_stall, obs_done); end
      @(negedge clk);
      total++; if (data_req !== 1'b0 || lsu_stall !== 1'b0) begin bad++;
         $display("FAIL slow_single got=%b%b exp=00", data_req, lsu_stall); end
      @(posedge clk); #1;
   endtask

   task automatic test_timeout;
      run_txn(1'b0, MEM_ACCESS_WORD, 32'h300, 32'h0, 100, 0, 32'h0);
      total++; if (obs_fault_n != 1 || obs_fault_k != 8) begin bad++;
         $display("FAIL to_fault got=n%0d/k%0d exp=n1/k8", obs_fault_n, obs_fault_k); end
      total++; if (obs_stall != 8 || obs_req != 8 || obs_valid_n != 0) begin bad++;
         $display("FAIL to_stall got=%0d/%0d/%0d exp=8/8/0", obs_stall, obs_req, obs_valid_n); end
      data_rvalid = 1'b1; data_rdata = 32'h11223344;
      @(negedge clk);
      total++; if ({data_req, lsu_stall, lsu_valid, lsu_fault} !== 4'b0000 || lsu_rd !== 32'h0) begin bad++;
         $display("FAIL to_late_rvalid got=%b/%h exp=0000/0", {data_req, lsu_stall, lsu_valid, lsu_fault}, lsu_rd); end
      @(posedge clk); #1;
      data_rvalid = 1'b0; data_rdata = 32'h0;
   endtask

   task automatic test_back_to_back;
      run_txn(1'b1, MEM_ACCESS_BYTE, 32'h102, 32'h0000005A, 0, 0, 32'h0);
      total++; if ({obs_be, obs_addr, obs_wdata} !== {4'b0100, 32'h100, 32'h5A5A5A5A} || obs_stall != 2) begin bad++;
         $display("FAIL b2b_sb got=%b/%h/%h/%0d exp=0100/00000100/5a5a5a5a/2", obs_be, obs_addr, obs_wdata, obs_stall); end
      run_txn(1'b0, MEM_ACCESS_WORD, 32'h200, 32'h0, 1, 0, 32'h12345678);
      total++; if (obs_ldata !== 32'h12345678 || obs_valid_n != 1 || obs_stall != 3) begin bad++;
         $display("FAIL b2b_lw got=%h/%0d/%0d exp=12345678/1/3", obs_ldata, obs_valid_n, obs_stall); end
   endtask

   task automatic test_async_reset;
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = MEM_ACCESS_WORD; lsu_addr = 32'h500;
      @(posedge clk); #1;
      data_gnt = 1'b1;
      @(posedge clk); #1;
      data_gnt = 1'b0;
      total++; if (data_req !== 1'b0 || lsu_stall !== 1'b1) begin bad++;
         $display("FAIL ar_in_wait got=%b%b exp=01", data_req, lsu_stall); end
      arstn = 1'b0; lsu_req = 1'b0;
      #1;
      total++; if ({data_req, lsu_stall, lsu_valid, lsu_fault} !== 4'b0000 || data_addr !== 32'h0) begin bad++;
         $display("FAIL ar_abort got=%b/%h exp=0000/0", {data_req, lsu_stall, lsu_valid, lsu_fault}, data_addr); end
      @(negedge clk);
      arstn = 1'b1;
      @(posedge clk); #1;
      run_txn(1'b0, MEM_ACCESS_WORD, 32'h504, 32'h0, 0, 0, 32'hA5A50F0F);
      total++; if (obs_ldata !== 32'hA5A50F0F || obs_addr !== 32'h504 || obs_valid_n != 1) begin bad++;
         $display("FAIL ar_post_lw got=%h/%h/%0d exp=a5a50f0f/00000504/1", obs_ldata, obs_addr, obs_valid_n); end
   endtask

   initial begin
      test_reset();
      test_store_word();
      test_loads();
      test_errors();
      test_stall_gnt();
      test_timeout();
      test_back_to_back();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
